// File: rtl/cyc_ctrl_pkg.sv
// Shared constants for the cycle counter controller: register map, bit positions
// and the sequencing state encoding.
package cyc_ctrl_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CNT_LO = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CNT_HI = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_CMP_LO = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CMP_HI = 3'd5;

    localparam int CTRL_RUN         = 0;
    localparam int CTRL_CLEAR       = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_AUTO_RELOAD = 3;

    localparam int STAT_RUNNING  = 0;
    localparam int STAT_MATCH    = 1;
    localparam int STAT_OVERFLOW = 2;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2
    } cyc_state_t;

endpackage

// File: rtl/cycle_count_core.sv
// Free-running cycle count register with synchronous clear and reload-to-zero.
// Clear wins over everything; the natural wrap at all-ones gives the overflow restart.
module cycle_count_core
    import cyc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             clr,
    input  logic             reload,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (reload) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign at_max = &count;

endmodule

// File: rtl/cycle_counter_ctrl.sv
// Memory-mapped control for the 32-bit cycle counter: run/halt sequencing,
// compare/overflow flags with interrupt, and tear-free split reads of the count.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   STOPPED | counter idle, waits for CTRL.run written 1
//   RUN     | counter increments every cycle halt is low
//   HALTED  | processor stalled, count frozen until halt drops
module cycle_counter_ctrl
    import cyc_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              halt,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              irq,
    output logic              running
);

    cyc_state_t        state;
    logic              run_bit;
    logic              irq_en;
    logic              auto_reload;
    logic              match_flag;
    logic              ovf_flag;
    logic [CNT_W-1:0]  cmp_val;
    logic [DATA_W-1:0] snap_hi;
    logic [CNT_W-1:0]  count;
    logic              at_max;
    logic [DATA_W-1:0] rd_mux;

    logic ctrl_wr;
    logic stat_wr;
    logic cmp_lo_wr;
    logic cmp_hi_wr;
    logic clr;
    logic en;
    logic hit;
    logic reload;

    assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
    assign stat_wr   = wr_en && (addr == ADDR_STATUS);
    assign cmp_lo_wr = wr_en && (addr == ADDR_CMP_LO);
    assign cmp_hi_wr = wr_en && (addr == ADDR_CMP_HI);

    // halt is honoured on the very edge it is first seen, before the state moves to HALTED
    assign en     = (state == RUN) && !halt;
    assign hit    = en && (count == cmp_val);
    assign reload = hit && auto_reload;
    assign clr    = ctrl_wr && wdata[CTRL_CLEAR];

    cycle_count_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .CLK    (CLK),
        .Reset  (Reset),
        .en     (en),
        .clr    (clr),
        .reload (reload),
        .count  (count),
        .at_max (at_max)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= STOPPED;
            running <= 1'b0;
        end else if (ctrl_wr && !wdata[CTRL_RUN]) begin
            state   <= STOPPED;
            running <= 1'b0;
        end else begin
            case (state)
                STOPPED: begin
                    if (ctrl_wr && wdata[CTRL_RUN]) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state   <= HALTED;
                        running <= 1'b0;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= STOPPED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            run_bit     <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            cmp_val     <= '0;
        end else begin
            if (ctrl_wr) begin
                run_bit     <= wdata[CTRL_RUN];
                irq_en      <= wdata[CTRL_IRQ_EN];
                auto_reload <= wdata[CTRL_AUTO_RELOAD];
            end
            if (cmp_lo_wr) begin
                cmp_val[DATA_W-1:0] <= wdata;
            end
            if (cmp_hi_wr) begin
                cmp_val[CNT_W-1:DATA_W] <= wdata;
            end
        end
    end

    // A flag being set on the same edge as its W1C clear stays set
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            match_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (hit) begin
                match_flag <= 1'b1;
            end else if (stat_wr && wdata[STAT_MATCH]) begin
                match_flag <= 1'b0;
            end
            if (en && at_max) begin
                ovf_flag <= 1'b1;
            end else if (stat_wr && wdata[STAT_OVERFLOW]) begin
                ovf_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_RUN]         = run_bit;
                rd_mux[CTRL_IRQ_EN]      = irq_en;
                rd_mux[CTRL_AUTO_RELOAD] = auto_reload;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_RUNNING]  = (state == RUN);
                rd_mux[STAT_MATCH]    = match_flag;
                rd_mux[STAT_OVERFLOW] = ovf_flag;
            end
            ADDR_CNT_LO: rd_mux = count[DATA_W-1:0];
            ADDR_CNT_HI: rd_mux = snap_hi;
            ADDR_CMP_LO: rd_mux = cmp_val[DATA_W-1:0];
            ADDR_CMP_HI: rd_mux = cmp_val[CNT_W-1:DATA_W];
            default:     rd_mux = '0;
        endcase
    end

    // Reading the low half freezes the matching high half so a later CNT_HI read cannot tear
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            snap_hi <= '0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_mux;
                if (addr == ADDR_CNT_LO) begin
                    snap_hi <= count[CNT_W-1:DATA_W];
                end
            end
        end
    end

    assign irq = irq_en & (match_flag | ovf_flag);

endmodule

// File: tb/tb_cycle_counter_ctrl.sv
// Scoreboard bench for cycle_counter_ctrl: reads push hand-computed values,
// a negedge monitor pops and compares whenever rvalid is presented.
module tb_cycle_counter_ctrl;

    logic        CLK;
    logic        Reset;
    logic [2:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic        halt;
    logic [15:0] rdata;
    logic        rvalid;
    logic        irq;
    logic        running;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    cycle_counter_ctrl dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .addr    (addr),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wdata   (wdata),
        .halt    (halt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .irq     (irq),
        .running (running)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete, %0d reads outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    always @(negedge CLK) begin
        if (rvalid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: rdata=0x%04h with no read outstanding", rdata);
            end else begin
                logic [15:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", nm, rdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, e);
        end
    endtask

    initial begin
        Reset = 1'b1;
        addr  = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        halt  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;

        // reset state
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, $sformatf("reset_rd%0d", i));
        chk("reset_irq", {15'd0, irq}, 16'd0);
        chk("reset_running", {15'd0, running}, 16'd0);

        // plain run for 10 cycles (cmp=0 so match sets on the first counted edge)
        wr(3'd0, 16'h0001);
        repeat (10) tick();
        rd(3'd2, 16'd10, "run10_lo");
        rd(3'd3, 16'd0, "run10_hi");
        rd(3'd1, 16'h0003, "run10_status");
        chk("run10_running", {15'd0, running}, 16'd1);

        // tear-free read across the 16-bit carry
        wr(3'd0, 16'h0002);
        wr(3'd1, 16'h0006);
        wr(3'd0, 16'h0001);
        repeat (65535) tick();
        rd(3'd2, 16'hFFFF, "carry_lo0");
        rd(3'd3, 16'h0000, "carry_hi0");
        rd(3'd2, 16'h0001, "carry_lo1");
        rd(3'd3, 16'h0001, "carry_hi1");

        // compare with auto-reload and interrupt
        wr(3'd0, 16'h0002);
        wr(3'd1, 16'h0006);
        wr(3'd4, 16'h0005);
        wr(3'd5, 16'h0000);
        rd(3'd1, 16'h0000, "cmp_status_pre");
        rd(3'd4, 16'h0005, "cmp_lo_rb");
        wr(3'd0, 16'h000D);
        rd(3'd2, 16'd0, "reload_c0");
        rd(3'd2, 16'd1, "reload_c1");
        rd(3'd2, 16'd2, "reload_c2");
        rd(3'd2, 16'd3, "reload_c3");
        rd(3'd2, 16'd4, "reload_c4");
        rd(3'd2, 16'd5, "reload_c5");
        rd(3'd2, 16'd0, "reload_c6");
        rd(3'd2, 16'd1, "reload_c7");
        chk("match_irq", {15'd0, irq}, 16'd1);
        wr(3'd1, 16'h0002);
        chk("w1c_irq", {15'd0, irq}, 16'd0);

        // halt freezes counting
        wr(3'd0, 16'h0002);
        wr(3'd4, 16'h0100);
        wr(3'd1, 16'h0006);
        wr(3'd0, 16'h0001);
        repeat (3) tick();
        halt = 1'b1;
        rd(3'd2, 16'd3, "halt_h0");
        rd(3'd2, 16'd3, "halt_h1");
        rd(3'd2, 16'd3, "halt_h2");
        rd(3'd2, 16'd3, "halt_h3");
        chk("halt_running", {15'd0, running}, 16'd0);
        rd(3'd1, 16'h0000, "halt_status");
        halt = 1'b0;
        rd(3'd2, 16'd3, "resume_r0");
        rd(3'd2, 16'd3, "resume_r1");
        chk("resume_running", {15'd0, running}, 16'd1);
        rd(3'd2, 16'd4, "resume_r2");
        rd(3'd2, 16'd5, "resume_r3");

        // clear written on the same edge as a match
        wr(3'd0, 16'h0002);
        wr(3'd1, 16'h0006);
        wr(3'd4, 16'h0003);
        wr(3'd0, 16'h0001);
        repeat (3) tick();
        wr(3'd0, 16'h0003);
        rd(3'd2, 16'd0, "clr_match_cnt");
        rd(3'd1, 16'h0003, "clr_match_status");
        rd(3'd0, 16'h0001, "ctrl_rb");
        rd(3'd4, 16'h0003, "cmp_lo_rb2");
        wr(3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, "addr6_rd");
        rd(3'd7, 16'h0000, "addr7_rd");

        // asynchronous reset mid-run with irq asserted
        wr(3'd0, 16'h0005);
        chk("pre_reset_irq", {15'd0, irq}, 16'd1);
        chk("pre_reset_running", {15'd0, running}, 16'd1);
        rd(3'd4, 16'h0003, "pre_reset_rd");
        @(negedge CLK);
        #1;
        Reset = 1'b1;
        #1;
        chk("async_rdata", rdata, 16'd0);
        chk("async_rvalid", {15'd0, rvalid}, 16'd0);
        chk("async_irq", {15'd0, irq}, 16'd0);
        chk("async_running", {15'd0, running}, 16'd0);
        #1;
        Reset = 1'b0;
        tick();
        rd(3'd0, 16'h0000, "post_reset_ctrl");
        rd(3'd1, 16'h0000, "post_reset_status");
        rd(3'd4, 16'h0000, "post_reset_cmp");
        rd(3'd2, 16'h0000, "post_reset_cnt");

        @(negedge CLK);
        @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_drained: %0d outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
